// File: rtl/rgb2ycbcr_arbiter_if.sv
// rtl/rgb2ycbcr_arbiter_if.sv - one requester's pixel request and converted-pixel return path
interface rgb2ycbcr_arbiter_if #(
  parameter int BIT_WIDTH = 8,
  parameter int V_BITW    = 9,
  parameter int H_BITW    = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_r;
  logic [BIT_WIDTH-1:0] in_g;
  logic [BIT_WIDTH-1:0] in_b;
  logic [V_BITW-1:0]    in_vcnt;
  logic [H_BITW-1:0]    in_hcnt;

  logic                 out_valid;
  logic [BIT_WIDTH-1:0] out_y;
  logic [BIT_WIDTH-1:0] out_cb;
  logic [BIT_WIDTH-1:0] out_cr;
  logic [V_BITW-1:0]    out_vcnt;
  logic [H_BITW-1:0]    out_hcnt;

  modport master (
    output in_valid, in_r, in_g, in_b, in_vcnt, in_hcnt,
    input  in_ready,
    input  out_valid, out_y, out_cb, out_cr, out_vcnt, out_hcnt
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_vcnt, in_hcnt,
    output in_ready,
    output out_valid, out_y, out_cb, out_cr, out_vcnt, out_hcnt
  );
endinterface

// File: rtl/rgb2ycbcr_arbiter.sv
// rtl/rgb2ycbcr_arbiter.sv - round-robin share of one rgb2ycbcr converter between two pixel requesters
module rgb2ycbcr_arbiter #(
  parameter int  BIT_WIDTH    = 8,
  parameter int  FRAME_HEIGHT = 480,
  parameter int  FRAME_WIDTH  = 640,
  parameter int  LATENCY      = 4,
  localparam int V_BITW       = $clog2(FRAME_HEIGHT),
  localparam int H_BITW       = $clog2(FRAME_WIDTH)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 cfg_fixed_prio,
  rgb2ycbcr_arbiter_if.slave   req0,
  rgb2ycbcr_arbiter_if.slave   req1,
  output logic [BIT_WIDTH-1:0] cv_r,
  output logic [BIT_WIDTH-1:0] cv_g,
  output logic [BIT_WIDTH-1:0] cv_b,
  output logic [V_BITW-1:0]    cv_vcnt,
  output logic [H_BITW-1:0]    cv_hcnt,
  input  logic [BIT_WIDTH-1:0] cv_y,
  input  logic [BIT_WIDTH-1:0] cv_cb,
  input  logic [BIT_WIDTH-1:0] cv_cr,
  input  logic [V_BITW-1:0]    cv_vcnt_o,
  input  logic [H_BITW-1:0]    cv_hcnt_o
);

  logic               last;
  logic               grant_v;
  logic               grant_id;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;

  // A grant is only ever issued to a valid requester, so grant_v is the accept.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = 1'b0;
    if (req0.in_valid && req1.in_valid) begin
      grant_v  = 1'b1;
      grant_id = cfg_fixed_prio ? 1'b0 : ~last;
    end else if (req0.in_valid) begin
      grant_v  = 1'b1;
      grant_id = 1'b0;
    end else if (req1.in_valid) begin
      grant_v  = 1'b1;
      grant_id = 1'b1;
    end
  end

  assign req0.in_ready = grant_v & ~grant_id;
  assign req1.in_ready = grant_v &  grant_id;

  always_comb begin
    cv_r    = '0;
    cv_g    = '0;
    cv_b    = '0;
    cv_vcnt = '0;
    cv_hcnt = '0;
    if (grant_v && !grant_id) begin
      cv_r    = req0.in_r;
      cv_g    = req0.in_g;
      cv_b    = req0.in_b;
      cv_vcnt = req0.in_vcnt;
      cv_hcnt = req0.in_hcnt;
    end else if (grant_v && grant_id) begin
      cv_r    = req1.in_r;
      cv_g    = req1.in_g;
      cv_b    = req1.in_b;
      cv_vcnt = req1.in_vcnt;
      cv_hcnt = req1.in_hcnt;
    end
  end

  // last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      last <= 1'b1;
    end else if (grant_v) begin
      last <= grant_id;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= grant_v;
      tag_id[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign req0.out_valid = tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
  assign req1.out_valid = tag_v[LATENCY-1] &  tag_id[LATENCY-1];

  // Converter data fans out to both owners; out_valid says whose it is.
  assign req0.out_y    = cv_y;
  assign req0.out_cb   = cv_cb;
  assign req0.out_cr   = cv_cr;
  assign req0.out_vcnt = cv_vcnt_o;
  assign req0.out_hcnt = cv_hcnt_o;
  assign req1.out_y    = cv_y;
  assign req1.out_cb   = cv_cb;
  assign req1.out_cr   = cv_cr;
  assign req1.out_vcnt = cv_vcnt_o;
  assign req1.out_hcnt = cv_hcnt_o;

endmodule
